// File: rtl/world_pkg.sv
// Shared encodings and heading helpers for the grid-world engine.
package world_pkg;
  localparam logic [1:0] ORI_N = 2'd0, ORI_S = 2'd1, ORI_E = 2'd2, ORI_W = 2'd3;
  localparam logic [2:0] EMPTY = 3'd0, WALL = 3'd1, BARRIER = 3'd2, TRASH = 3'd7;

  typedef enum logic [1:0] {ST_IDLE, ST_UPDATE, ST_SENSE} state_e;

  typedef struct packed {
    logic signed [1:0] dr;
    logic signed [1:0] dc;
  } offset_t;

  // Offset to the cell ahead (left_side=0) or to the left-hand cell (left_side=1).
  function automatic offset_t nb_offset(input logic [1:0] ori, input logic left_side);
    offset_t o;
    o.dr = 2'sd0;
    o.dc = 2'sd0;
    case (ori)
      ORI_N: if (left_side) o.dc = -2'sd1; else o.dr = -2'sd1;
      ORI_S: if (left_side) o.dc =  2'sd1; else o.dr =  2'sd1;
      ORI_E: if (left_side) o.dr = -2'sd1; else o.dc =  2'sd1;
      default: if (left_side) o.dr = 2'sd1; else o.dc = -2'sd1;
    endcase
    return o;
  endfunction

  function automatic logic [1:0] turn_left(input logic [1:0] ori);
    case (ori)
      ORI_N:   return ORI_W;
      ORI_W:   return ORI_S;
      ORI_S:   return ORI_E;
      default: return ORI_N;
    endcase
  endfunction
endpackage

// File: rtl/grid_world_engine_if.sv
// Robot / map-loader / graphics connection bundle of the grid-world engine.
interface grid_world_engine_if #(parameter int COORD_W = 6);
  logic [COORD_W-1:0] init_row, init_column;
  logic [1:0]         init_orientation;
  logic               step, ready, front, turn, remove;
  logic               head, left, under, barrier, collision;
  logic [COORD_W-1:0] robot_row, robot_column;
  logic [1:0]         robot_orientation;
  logic               wr_en;
  logic [COORD_W-1:0] wr_row, wr_column, rd_row, rd_column;
  logic [2:0]         wr_data, rd_data;

  modport master (
    output init_row, init_column, init_orientation, step, front, turn, remove,
           wr_en, wr_row, wr_column, wr_data, rd_row, rd_column,
    input  ready, head, left, under, barrier, collision,
           robot_row, robot_column, robot_orientation, rd_data
  );
  modport slave (
    input  init_row, init_column, init_orientation, step, front, turn, remove,
           wr_en, wr_row, wr_column, wr_data, rd_row, rd_column,
    output ready, head, left, under, barrier, collision,
           robot_row, robot_column, robot_orientation, rd_data
  );
endinterface

// File: rtl/grid_map_ram.sv
// Cell map: one sync write port, one registered read port, two combinational probes.
module grid_map_ram #(
  parameter int DEPTH = 200,
  parameter int AW    = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [2:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [2:0]    rdata,
  input  logic [AW-1:0] pa_addr,
  output logic [2:0]    pa_data,
  input  logic [AW-1:0] pb_addr,
  output logic [2:0]    pb_data
);
  logic [2:0] mem_q [DEPTH];
  logic [2:0] mem_d [DEPTH];
  logic [2:0] rdata_q, rdata_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_comb rdata_d = re ? mem_q[raddr] : 3'd0;

  always_ff @(posedge clock) begin
    if (reset) mem_q <= '{default: 3'd0};
    else       mem_q <= mem_d;
  end

  // Graphics read port keeps running through reset.
  always_ff @(posedge clock) rdata_q <= rdata_d;

  assign rdata   = rdata_q;
  assign pa_data = mem_q[pa_addr];
  assign pb_data = mem_q[pb_addr];
endmodule

// File: rtl/grid_world_engine.sv
// Grid-world simulator: robot pose FSM (IDLE/UPDATE/SENSE), remove counter and sensors.
module grid_world_engine import world_pkg::*; #(
  parameter int ROWS          = 10,
  parameter int COLS          = 20,
  parameter int COORD_W       = 6,
  parameter int REMOVE_CYCLES = 3
) (
  input logic clock,
  input logic reset,
  grid_world_engine_if.slave bus
);
  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(REMOVE_CYCLES + 1);

  typedef logic [COORD_W:0] coord_t;

  function automatic logic on_grid(input coord_t r, input coord_t c);
    return (32'(r) >= 32'd1) && (32'(r) <= ROWS) && (32'(c) >= 32'd1) && (32'(c) <= COLS);
  endfunction

  function automatic logic [AW-1:0] cell_idx(input coord_t r, input coord_t c);
    return AW'((32'(r) - 32'd1) * 32'(COLS) + 32'(c) - 32'd1);
  endfunction

  // One extra bit keeps row-1 at row 1 from aliasing onto a legal coordinate.
  function automatic coord_t nb_coord(input logic [COORD_W-1:0] p, input logic signed [1:0] d);
    return {1'b0, p} + {{(COORD_W-1){d[1]}}, d};
  endfunction

  state_e             state_q, state_d;
  logic [COORD_W-1:0] row_q, row_d, col_q, col_d;
  logic [1:0]         ori_q, ori_d;
  logic               front_q, front_d, turn_q, turn_d, remove_q, remove_d;
  logic               coll_q, coll_d, head_q, head_d, left_q, left_d;
  logic               under_q, under_d, barrier_q, barrier_d, own_trash_q, own_trash_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  offset_t       off_f, off_l;
  coord_t        fr, fc, lr, lc, orow, ocol, wr_r, wr_c, rd_r, rd_c;
  logic          front_on, left_on, own_on, pb_on, wr_on, rd_on;
  logic [2:0]    front_val, pb_val, wdata;
  logic [AW-1:0] pa_addr, pb_addr, waddr;
  logic          we, blocked, moved, last_remove, clear_now;

  assign off_f    = nb_offset(ori_q, 1'b0);
  assign off_l    = nb_offset(ori_q, 1'b1);
  assign fr       = nb_coord(row_q, off_f.dr);
  assign fc       = nb_coord(col_q, off_f.dc);
  assign lr       = nb_coord(row_q, off_l.dr);
  assign lc       = nb_coord(col_q, off_l.dc);
  assign orow     = {1'b0, row_q};
  assign ocol     = {1'b0, col_q};
  assign wr_r     = {1'b0, bus.wr_row};
  assign wr_c     = {1'b0, bus.wr_column};
  assign rd_r     = {1'b0, bus.rd_row};
  assign rd_c     = {1'b0, bus.rd_column};
  assign front_on = on_grid(fr, fc);
  assign left_on  = on_grid(lr, lc);
  assign own_on   = on_grid(orow, ocol);
  assign wr_on    = on_grid(wr_r, wr_c);
  assign rd_on    = on_grid(rd_r, rd_c);
  assign pa_addr  = front_on ? cell_idx(fr, fc) : '0;

  assign blocked     = !front_on || front_val == WALL || front_val == BARRIER;
  assign moved       = front_q && !blocked;
  assign last_remove = (cnt_q == CNT_W'(REMOVE_CYCLES - 1));
  assign clear_now   = !front_q && !turn_q && remove_q && last_remove && front_on && front_val == BARRIER;

  grid_map_ram #(.DEPTH(DEPTH), .AW(AW)) u_map (
    .clock  (clock),
    .reset  (reset),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re     (rd_on),
    .raddr  (rd_on ? cell_idx(rd_r, rd_c) : '0),
    .rdata  (bus.rd_data),
    .pa_addr(pa_addr),
    .pa_data(front_val),
    .pb_addr(pb_addr),
    .pb_data(pb_val)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_SENSE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.step) state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_SENSE;
      ST_SENSE:  state_d = ST_IDLE;
      default:   state_d = ST_SENSE;
    endcase
  end

  // Probe B looks at the own cell during UPDATE so the under flag is known before SENSE.
  always_comb begin
    bus.ready = (state_q == ST_IDLE);
    pb_on     = (state_q == ST_UPDATE) ? own_on : left_on;
    pb_addr   = '0;
    if (state_q == ST_UPDATE) begin
      if (own_on) pb_addr = cell_idx(orow, ocol);
    end else if (left_on) begin
      pb_addr = cell_idx(lr, lc);
    end
    we    = 1'b0;
    waddr = wr_on ? cell_idx(wr_r, wr_c) : '0;
    wdata = bus.wr_data;
    if (state_q == ST_IDLE && bus.wr_en && wr_on) begin
      we = 1'b1;
    end else if (state_q == ST_UPDATE && clear_now) begin
      we    = 1'b1;
      waddr = pa_addr;
      wdata = EMPTY;
    end
  end

  always_comb begin
    row_d = row_q;  col_d = col_q;  ori_d = ori_q;
    front_d = front_q;  turn_d = turn_q;  remove_d = remove_q;
    coll_d = coll_q;  head_d = head_q;  left_d = left_q;
    under_d = under_q;  barrier_d = barrier_q;  own_trash_d = own_trash_q;
    cnt_d = cnt_q;
    case (state_q)
      ST_IDLE: if (bus.step) begin
        front_d  = bus.front;
        turn_d   = bus.turn;
        remove_d = bus.remove;
      end
      ST_UPDATE: begin
        own_trash_d = moved ? (front_val == TRASH) : (pb_on && pb_val == TRASH);
        cnt_d       = '0;
        if (front_q) begin
          if (blocked) coll_d = 1'b1;
          else begin
            row_d = fr[COORD_W-1:0];
            col_d = fc[COORD_W-1:0];
          end
        end else if (turn_q) begin
          ori_d = turn_left(ori_q);
        end else if (remove_q && !last_remove) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SENSE: begin
        head_d    = !front_on || front_val == WALL;
        left_d    = !pb_on || pb_val == WALL;
        barrier_d = front_on && front_val == BARRIER;
        under_d   = own_trash_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      row_q <= bus.init_row;  col_q <= bus.init_column;  ori_q <= bus.init_orientation;
      front_q <= 1'b0;  turn_q <= 1'b0;  remove_q <= 1'b0;
      coll_q <= 1'b0;  head_q <= 1'b0;  left_q <= 1'b0;
      under_q <= 1'b0;  barrier_q <= 1'b0;  own_trash_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      row_q <= row_d;  col_q <= col_d;  ori_q <= ori_d;
      front_q <= front_d;  turn_q <= turn_d;  remove_q <= remove_d;
      coll_q <= coll_d;  head_q <= head_d;  left_q <= left_d;
      under_q <= under_d;  barrier_q <= barrier_d;  own_trash_q <= own_trash_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.robot_row         = row_q;
  assign bus.robot_column      = col_q;
  assign bus.robot_orientation = ori_q;
  assign bus.collision         = coll_q;
  assign bus.head              = head_q;
  assign bus.left              = left_q;
  assign bus.under             = under_q;
  assign bus.barrier           = barrier_q;
endmodule
